// File: rtl/wavenet_pkg.sv
// Shared definitions for the WaveNet streaming stages: sample format,
// the saturating clamp back to Q8.8 and the common two-state stream enum.
package wavenet_pkg;

   localparam int DATA_W    = 16;
   localparam int FRAC_BITS = 8;
   // Widest accumulator sat16 accepts; callers sign-extend into it.
   localparam int SAT_IN_W  = 48;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      DRAIN = 1'b1
   } stream_state_e;

   function automatic logic signed [15:0] sat16(input logic signed [SAT_IN_W-1:0] v);
      logic signed [15:0] r;
      if (v > 48'sd32767) begin
         r = 16'sh7FFF;
      end else if (v < -48'sd32768) begin
         r = 16'sh8000;
      end else begin
         r = v[15:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/skip_acc_ram.sv
// Per-channel accumulator storage: one synchronous write port and one
// asynchronous read port, shaped so it can be swapped for block RAM later.
module skip_acc_ram #(
   parameter int DEPTH  = 512,
   parameter int WIDTH  = 20,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage is left unreset: layer 0 of every timestep overwrites each entry.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end else begin
         mem_q[waddr_i] <= mem_q[waddr_i];
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/skip_accumulator.sv
// Sums NUM_LAYERS channel-serial skip vectors per timestep, then drains the
// saturated sums. Define SKIP_RELU_EN to force negative drained sums to zero.
module skip_accumulator #(
   parameter int SKIP_CHANNELS = 512,
   parameter int NUM_LAYERS    = 8,
   parameter int DATA_W        = wavenet_pkg::DATA_W,
   parameter int ACC_W         = DATA_W + $clog2(NUM_LAYERS) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
);

   import wavenet_pkg::*;

   localparam int CH_W = (SKIP_CHANNELS > 1) ? $clog2(SKIP_CHANNELS) : 1;
   localparam int LY_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(SKIP_CHANNELS - 1);
   localparam logic [LY_W-1:0] LY_LAST = LY_W'(NUM_LAYERS - 1);

   stream_state_e            state_q, state_d;
   logic [CH_W-1:0]          ch_q, ch_d;
   logic [LY_W-1:0]          layer_q, layer_d;
   logic                     live_q;

   logic                     wr_en_s;
   logic signed [ACC_W-1:0]  wr_data_s;
   logic signed [ACC_W-1:0]  rd_data_s;
   logic signed [ACC_W-1:0]  in_ext_s;
   logic                     in_fire_s;
   logic                     out_fire_s;
   logic                     ch_last_s;
   logic                     layer_last_s;
   logic signed [15:0]       sat_s;
   logic [DATA_W-1:0]        drain_val_s;

   skip_acc_ram #(
      .DEPTH  (SKIP_CHANNELS),
      .WIDTH  (ACC_W),
      .ADDR_W (CH_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_en_s),
      .waddr_i (ch_q),
      .wdata_i (wr_data_s),
      .raddr_i (ch_q),
      .rdata_o (rd_data_s)
   );

   // State, channel/layer counters and the out-of-reset flag gating in_ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ACCUM;
         ch_q    <= '0;
         layer_q <= '0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         layer_q <= layer_d;
         live_q  <= 1'b1;
      end
   end

   assign in_ready     = live_q && (state_q == ACCUM);
   assign out_valid    = (state_q == DRAIN);
   assign in_fire_s    = in_valid && in_ready;
   assign out_fire_s   = out_valid && out_ready;
   assign ch_last_s    = (ch_q == CH_LAST);
   assign layer_last_s = (layer_q == LY_LAST);
   assign in_ext_s     = ACC_W'($signed(in_data));
   assign busy         = !((state_q == ACCUM) && (ch_q == '0) && (layer_q == '0));

   // Next-state logic; layer 0 overwrites the entry so no clear pass is needed.
   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      layer_d   = layer_q;
      wr_en_s   = 1'b0;
      wr_data_s = '0;
      case (state_q)
         ACCUM: begin
            if (in_fire_s) begin
               wr_en_s = 1'b1;
               if (layer_q == '0) begin
                  wr_data_s = in_ext_s;
               end else begin
                  wr_data_s = rd_data_s + in_ext_s;
               end
               if (ch_last_s) begin
                  ch_d = '0;
                  if (layer_last_s) begin
                     layer_d = '0;
                     state_d = DRAIN;
                  end else begin
                     layer_d = layer_q + LY_W'(1);
                  end
               end else begin
                  ch_d = ch_q + CH_W'(1);
               end
            end else begin
               ch_d = ch_q;
            end
         end
         DRAIN: begin
            if (out_fire_s) begin
               if (ch_last_s) begin
                  ch_d    = '0;
                  state_d = ACCUM;
               end else begin
                  ch_d = ch_q + CH_W'(1);
               end
            end else begin
               ch_d = ch_q;
            end
         end
         default: begin
            state_d = ACCUM;
            ch_d    = '0;
            layer_d = '0;
         end
      endcase
   end

   // Drain value straight from the array so it holds while out_ready is low.
   always_comb begin
      sat_s = sat16(SAT_IN_W'(rd_data_s));
`ifdef SKIP_RELU_EN
      if (sat_s[15]) begin
         drain_val_s = '0;
      end else begin
         drain_val_s = DATA_W'(sat_s);
      end
`else
      drain_val_s = DATA_W'(sat_s);
`endif
      if (state_q == DRAIN) begin
         out_data = drain_val_s;
         out_last = ch_last_s;
      end else begin
         out_data = '0;
         out_last = 1'b0;
      end
   end

endmodule

// File: tb/tb_skip_accumulator.sv
// Self-checking bench for skip_accumulator (4 channels, 2 layers) against a
// per-channel sum/clamp reference model.
module tb_skip_accumulator;

   localparam int CH = 4;
   localparam int NL = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = 16'h0000;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_last;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   logic signed [15:0] stim [NL][CH];
   logic [15:0]        got_data [CH];
   logic               got_last [CH];
   bit                 tmo;

   always #5 clk = ~clk;

   skip_accumulator #(
      .SKIP_CHANNELS (CH),
      .NUM_LAYERS    (NL)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   function automatic logic [15:0] model_out(input int c);
      int s;
      s = 0;
      for (int l = 0; l < NL; l++) s += int'(stim[l][c]);
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
`ifdef SKIP_RELU_EN
      if (s < 0) s = 0;
`endif
      return 16'(s);
   endfunction

   task automatic randomize_stim();
      for (int l = 0; l < NL; l++)
         for (int c = 0; c < CH; c++)
            stim[l][c] = 16'($urandom());
   endtask

   // Offers every beat of stim in layer/channel order, idling gap_pct% of cycles.
   task automatic drive_timestep(input int gap_pct);
      int  budget;
      bit  done;
      tmo = 1'b0;
      for (int l = 0; l < NL; l++) begin
         for (int c = 0; c < CH; c++) begin
            in_data = stim[l][c];
            budget = 0;
            done = 1'b0;
            while (!done) begin
               in_valid = (int'($urandom_range(0, 99)) >= gap_pct);
               done = in_valid && in_ready;
               @(posedge clk); #1;
               budget++;
               if (budget > 200) begin
                  tmo = 1'b1;
                  done = 1'b1;
               end
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic collect();
      int n;
      int budget;
      n = 0;
      budget = 0;
      out_ready = 1'b1;
      while (n < CH && budget < 200) begin
         if (out_valid) begin
            got_data[n] = out_data;
            got_last[n] = out_last;
            n++;
         end
         @(posedge clk); #1;
         budget++;
      end
      if (n < CH) tmo = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks += 5;
      if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      if (out_data !== 16'h0000) begin n_errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
      if (out_last !== 1'b0) begin n_errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
      if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks += 2;
      if (in_ready !== 1'b1) begin n_errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
      if (busy !== 1'b0) begin n_errors++; $display("FAIL release_busy got %b want 0", busy); end
   endtask

   task automatic test_basic();
      logic [15:0] want;
      for (int c = 0; c < CH; c++) begin
         stim[0][c] = 16'((c + 1) * 256);
         stim[1][c] = 16'((c + 1) * 10 * 256);
      end
      drive_timestep(0);
      n_checks += 3;
      if (tmo) begin n_errors++; $display("FAIL basic_input_timeout got 1 want 0"); end
      if (out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_latency out_valid got %b want 1", out_valid); end
      if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy got %b want 1", busy); end
      collect();
      n_checks++;
      if (tmo) begin n_errors++; $display("FAIL basic_drain_timeout got 1 want 0"); end
      for (int c = 0; c < CH; c++) begin
         want = 16'((c + 1) * 11 * 256);
         n_checks += 2;
         if (got_data[c] !== want) begin n_errors++; $display("FAIL basic_data[%0d] got %h want %h", c, got_data[c], want); end
         if (got_last[c] !== (c == CH - 1)) begin n_errors++; $display("FAIL basic_last[%0d] got %b want %b", c, got_last[c], (c == CH - 1)); end
      end
      n_checks += 3;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_after_valid got %b want 0", out_valid); end
      if (in_ready !== 1'b1) begin n_errors++; $display("FAIL basic_after_ready got %b want 1", in_ready); end
      if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_after_busy got %b want 0", busy); end
   endtask

   task automatic test_saturation();
      logic [15:0] v;
      logic [15:0] want;
      for (int p = 0; p < 2; p++) begin
         if (p == 0) begin
            v = 16'h7000;
            want = 16'h7FFF;
         end else begin
            v = 16'h9000;
`ifdef SKIP_RELU_EN
            want = 16'h0000;
`else
            want = 16'h8000;
`endif
         end
         for (int l = 0; l < NL; l++)
            for (int c = 0; c < CH; c++)
               stim[l][c] = v;
         drive_timestep(0);
         collect();
         n_checks++;
         if (tmo) begin n_errors++; $display("FAIL sat_timeout got 1 want 0"); end
         for (int c = 0; c < CH; c++) begin
            n_checks++;
            if (got_data[c] !== want) begin n_errors++; $display("FAIL sat_%h[%0d] got %h want %h", v, c, got_data[c], want); end
         end
      end
   endtask

   task automatic test_backpressure();
      int          beats;
      int          cyc;
      bit          stalled;
      logic [15:0] held;
      randomize_stim();
      drive_timestep(0);
      beats = 0;
      cyc = 0;
      stalled = 1'b0;
      held = 16'h0000;
      while (beats < CH && cyc < 100) begin
         out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         n_checks += 2;
         if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid cyc %0d got %b want 1", cyc, out_valid); end
         if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", cyc, in_ready); end
         if (stalled) begin
            n_checks++;
            if (out_data !== held) begin n_errors++; $display("FAIL bp_hold cyc %0d got %h want %h", cyc, out_data, held); end
         end
         if (out_valid && out_ready) begin
            got_data[beats] = out_data;
            beats++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held = out_data;
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b1;
      n_checks++;
      if (beats !== CH) begin n_errors++; $display("FAIL bp_beats got %0d want %0d", beats, CH); end
      for (int c = 0; c < CH; c++) begin
         n_checks++;
         if (got_data[c] !== model_out(c)) begin n_errors++; $display("FAIL bp_data[%0d] got %h want %h", c, got_data[c], model_out(c)); end
      end
      repeat (3) begin
         n_checks += 2;
         if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_extra_beat got %b want 0", out_valid); end
         if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_after_ready got %b want 1", in_ready); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      randomize_stim();
      drive_timestep(0);
      collect();
      for (int c = 0; c < CH; c++) begin
         n_checks++;
         if (got_data[c] !== model_out(c)) begin n_errors++; $display("FAIL b2b_first[%0d] got %h want %h", c, got_data[c], model_out(c)); end
      end
      for (int c = 0; c < CH; c++) begin
         stim[0][c] = 16'h0500;
         stim[1][c] = 16'h0000;
      end
      drive_timestep(0);
      collect();
      n_checks++;
      if (tmo) begin n_errors++; $display("FAIL b2b_timeout got 1 want 0"); end
      for (int c = 0; c < CH; c++) begin
         n_checks++;
         if (got_data[c] !== 16'h0500) begin n_errors++; $display("FAIL b2b_second[%0d] got %h want 0500", c, got_data[c]); end
      end
   endtask

   task automatic test_reset_mid();
      randomize_stim();
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_data = stim[0][k];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin n_errors++; $display("FAIL mid_busy_before got %b want 1", busy); end
      #2;
      reset = 1'b0;
      #1;
      n_checks += 3;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL mid_busy_reset got %b want 0", busy); end
      if (in_ready !== 1'b0) begin n_errors++; $display("FAIL mid_ready_reset got %b want 0", in_ready); end
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_valid_reset got %b want 0", out_valid); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      randomize_stim();
      drive_timestep(0);
      collect();
      n_checks++;
      if (tmo) begin n_errors++; $display("FAIL mid_timeout got 1 want 0"); end
      for (int c = 0; c < CH; c++) begin
         n_checks++;
         if (got_data[c] !== model_out(c)) begin n_errors++; $display("FAIL mid_data[%0d] got %h want %h", c, got_data[c], model_out(c)); end
      end
   endtask

   task automatic test_random_gaps();
      for (int it = 0; it < 6; it++) begin
         randomize_stim();
         for (int pass = 0; pass < 2; pass++) begin
            drive_timestep((pass == 0) ? 30 : 0);
            collect();
            n_checks++;
            if (tmo) begin n_errors++; $display("FAIL gaps_timeout it %0d got 1 want 0", it); end
            for (int c = 0; c < CH; c++) begin
               n_checks++;
               if (got_data[c] !== model_out(c)) begin
                  n_errors++;
                  $display("FAIL gaps_data it %0d pass %0d ch %0d got %h want %h", it, pass, c, got_data[c], model_out(c));
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random_gaps();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
